// File: rtl/gemm_activation_feeder_pkg.sv
// Shared types for the GEMM activation feeder.
// Holds the feeder FSM state type and the drain length helper.
package GEMM_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

  // Zero vectors needed to push the last real
  // vector fully through a square array.
  function automatic int drain_len(input int sa_size);
    return 2 * sa_size;
  endfunction

endpackage

// File: rtl/gemm_act_fifo.sv
// Synchronous FIFO buffering activation vectors.
// Ports: clk, resetn, push/wdata, pop/rdata, count, full, empty.
module gemm_act_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer
  // overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gemm_activation_feeder.sv
// Feeds buffered activation vectors into a systolic array, then drains it.
// Ports: in_valid/in_ready/in_data/in_last, sa_hold, sa_inputs,
// sa_advance, busy, flush_done, fifo_count.
module gemm_activation_feeder
  import GEMM_pkg::*;
#(
  parameter int SA_SIZE                = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                                         clk,
  input  logic                                         resetn,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_data,
  input  logic                                         in_last,
  input  logic                                         sa_hold,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_inputs,
  output logic                                         sa_advance,
  output logic                                         busy,
  output logic                                         flush_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]              fifo_count
);

  localparam int EW    = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
  localparam int DRAIN = drain_len(SA_SIZE);
  localparam int DW    = $clog2(DRAIN+1);

  typedef logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] vec_t;

  feeder_state_t state, state_d;
  logic [DW-1:0] drain, drain_d;
  logic [EW:0]   head;
  vec_t          head_vec;
  logic          head_last;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          adv_d;
  vec_t          inputs_d;
  logic          done_d;

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign head_vec  = head[EW-1:0];
  assign head_last = head[EW];
  assign busy      = (state != IDLE);

  gemm_act_fifo #(
    .WIDTH(EW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  ({in_last, in_data}),
    .pop    (pop),
    .rdata  (head),
    .count  (fifo_count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      drain      <= '0;
      sa_advance <= 1'b0;
      sa_inputs  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_d;
      drain      <= drain_d;
      sa_advance <= adv_d;
      sa_inputs  <= inputs_d;
      flush_done <= done_d;
    end
  end

  // The cycle after the last drain advance is spent
  // returning to IDLE with flush_done, so a vector queued
  // during FLUSH pops one edge after that.
  always_comb begin
    state_d  = state;
    drain_d  = drain;
    pop      = 1'b0;
    adv_d    = 1'b0;
    inputs_d = '0;
    done_d   = 1'b0;
    unique case (state)
      IDLE, STREAM: begin
        if (!empty && !sa_hold) begin
          pop      = 1'b1;
          adv_d    = 1'b1;
          inputs_d = head_vec;
        end
        if (pop && head_last) begin
          state_d = FLUSH;
        end else if (!empty) begin
          state_d = STREAM;
        end
      end
      FLUSH: begin
        if (drain == DW'(DRAIN)) begin
          state_d = IDLE;
          drain_d = '0;
          done_d  = 1'b1;
        end else if (!sa_hold) begin
          adv_d   = 1'b1;
          drain_d = drain + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gemm_activation_feeder.sv
// Scoreboard bench for gemm_activation_feeder (SA_SIZE=2, depth 4).
// Drives vectors, predicts the emitted stream and flush_done timing.
module tb_gemm_activation_feeder;

  localparam int SA  = 2;
  localparam int WA  = 8;
  localparam int FD  = 4;
  localparam int CW  = $clog2(FD+1);

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 in_valid;
  logic                 in_ready;
  logic [SA-1:0][WA-1:0] in_data;
  logic                 in_last;
  logic                 sa_hold;
  logic [SA-1:0][WA-1:0] sa_inputs;
  logic                 sa_advance;
  logic                 busy;
  logic                 flush_done;
  logic [CW-1:0]        fifo_count;

  typedef struct {
    logic [15:0] data;
    bit          zero;
    bit          fin;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   exp_done = 1'b0;
  int   zero_adv = 0;

  always #5 clk = ~clk;

  gemm_activation_feeder #(
    .SA_SIZE(SA),
    .WEIGHT_ACTIVATION_SIZE(WA),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sa_hold    (sa_hold),
    .sa_inputs  (sa_inputs),
    .sa_advance (sa_advance),
    .busy       (busy),
    .flush_done (flush_done),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] a,
                                     input logic [7:0] b);
    return {b, a};
  endfunction

  task automatic sb_push(input logic [15:0] d, input bit last);
    exp_t e;
    e.data = d;
    e.zero = 1'b0;
    e.fin  = 1'b0;
    sbq.push_back(e);
    if (last) begin
      for (int i = 0; i < 2*SA; i++) begin
        e.data = '0;
        e.zero = 1'b1;
        e.fin  = (i == 2*SA-1);
        sbq.push_back(e);
      end
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic push_vec(input logic [15:0] d, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("push_timeout", 0, 1);
    end else begin
      @(posedge clk);
      sb_push(d, last);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (!busy && sbq.size() == 0 && !exp_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 1);
  endtask

  // Monitor: every advance pops the scoreboard; flush_done
  // must appear exactly one cycle after the final zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_done || flush_done) begin
          chk("flush_done", 32'(flush_done), 32'(exp_done));
          if (flush_done) chk("busy_at_done", 32'(busy), 0);
        end
        exp_done = 1'b0;
        if (sa_advance) begin
          if (sbq.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("sa_inputs", 32'(sa_inputs), 32'(e.data));
            if (e.fin) exp_done = 1'b1;
            if (e.zero) zero_adv++;
          end
        end else begin
          chk("idle_zero", 32'(sa_inputs), 0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    int base;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    sa_hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_adv", 32'(sa_advance), 0);
    chk("rst_inputs", 32'(sa_inputs), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(flush_done), 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // single last vector: latency and drain
    push_vec(mk(8'd2, 8'd5), 1'b1);
    chk("lat_acc_adv", 32'(sa_advance), 0);
    chk("lat_acc_cnt", 32'(fifo_count), 1);
    @(posedge clk);
    #1;
    chk("lat_pop_adv", 32'(sa_advance), 1);
    chk("lat_pop_busy", 32'(busy), 1);
    wait_idle();

    // back-pressure fills the FIFO
    sa_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_vec(mk(8'(16 + i), 8'(32 + i)), 1'b0);
    end
    chk("full_ready", 32'(in_ready), 0);
    chk("full_count", 32'(fifo_count), 4);
    fork
      push_vec(mk(8'd20, 8'd36), 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_cnt", 32'(fifo_count), 4);
        chk("full_hold_rdy", 32'(in_ready), 0);
        sa_hold = 1'b0;
      end
    join
    wait_idle();

    // hold toggling during the drain
    fork
      push_vec(mk(8'd9, 8'd4), 1'b1);
      begin
        repeat (24) begin
          @(posedge clk);
          #1;
          sa_hold = ~sa_hold;
        end
        sa_hold = 1'b0;
      end
    join
    wait_idle();

    // vector queued during FLUSH waits for flush_done
    push_vec(mk(8'd1, 8'd1), 1'b0);
    push_vec(mk(8'd2, 8'd2), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("in_flush_busy", 32'(busy), 1);
    push_vec(mk(8'd3, 8'd3), 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (flush_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(ok), 1);
    chk("done_cyc_adv", 32'(sa_advance), 0);
    @(negedge clk);
    chk("after_done_adv", 32'(sa_advance), 1);
    chk("after_done_data", 32'(sa_inputs), 32'(mk(8'd3, 8'd3)));
    #1;
    push_vec(mk(8'd8, 8'd8), 1'b1);
    wait_idle();

    // reset in the middle of the drain
    push_vec(mk(8'd7, 8'd7), 1'b1);
    push_vec(mk(8'd6, 8'd6), 1'b0);
    base = zero_adv;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (zero_adv >= base + 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("two_zero_adv", 32'(ok), 1);
    chk("pre_rst_count", 32'(fifo_count), 1);
    resetn = 1'b0;
    sbq.delete();
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_adv", 32'(sa_advance), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(flush_done), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    #1;

    // steady push+pop with two queued, across pointer wrap
    sa_hold = 1'b1;
    push_vec(mk(8'd40, 8'd41), 1'b0);
    push_vec(mk(8'd42, 8'd43), 1'b0);
    chk("steady_pre", 32'(fifo_count), 2);
    sa_hold  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = mk(8'(i*3 + 1), 8'(i*7 + 2));
      in_last = (i == 9);
      chk("steady_rdy", 32'(in_ready), 1);
      @(posedge clk);
      sb_push(mk(8'(i*3 + 1), 8'(i*7 + 2)), (i == 9));
      #1;
      chk("steady_cnt", 32'(fifo_count), 2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gemm_activation_feeder.md
GEMM_ACTIVATION_FEEDER -- requirements
Module: gemm_activation_feeder

Interface
REQ-001 SHALL have parameter SA_SIZE, default 2, systolic array dimension (activation vector length).
REQ-002 SHALL have parameter WEIGHT_ACTIVATION_SIZE, default 8, bits per activation element.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of buffered activation vectors; a power of two of at least 2.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port resetn  input  1  reset: synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream vector valid.
REQ-007 SHALL have port in_ready  output  1  feeder can accept a vector.
REQ-008 SHALL have port in_data  input  SA_SIZE x WEIGHT_ACTIVATION_SIZE  activation vector.
REQ-009 SHALL have port in_last  input  1  marks the final vector of a batch; qualified by in_valid.
REQ-010 SHALL have port sa_hold  input  1  downstream back-pressure; freezes advancement.
REQ-011 SHALL have port sa_inputs  output  SA_SIZE x WEIGHT_ACTIVATION_SIZE  vector to the array activation inputs.
REQ-012 SHALL have port sa_advance  output  1  drives the array should_advance_computation.
REQ-013 SHALL have port busy  output  1  high while in STREAM or FLUSH.
REQ-014 SHALL have port flush_done  output  1  single-cycle pulse when a batch drain completes.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-016 SHALL transfer a vector on a rising edge where in_valid && in_ready; in_ready = (fifo_count < FIFO_DEPTH), with no credit given for a same-cycle pop.
REQ-017 SHALL store in_last with each vector in the FIFO.
REQ-018 SHALL implement FSM states IDLE, STREAM and FLUSH.
- IDLE->STREAM when the FIFO is non-empty.
- STREAM->FLUSH on the edge that pops a vector whose last flag is set.
- FLUSH->IDLE after the drain count completes.
REQ-019 SHALL, in IDLE or STREAM with the FIFO non-empty and sa_hold=0, pop the head vector on the edge and register it into sa_inputs with sa_advance=1 for the following cycle.
REQ-020 SHALL have a latency of 2 edges from the acceptance edge to the sa_advance=1 cycle when the FIFO was empty: the accept edge, then the pop edge.
REQ-021 SHALL, in FLUSH with sa_hold=0, issue exactly 2*SA_SIZE advance cycles with sa_inputs all zero, counted by a drain counter; hold cycles do not count.
REQ-022 SHALL pulse flush_done for the cycle after the final flush advance, and SHALL be in IDLE in that same cycle.
REQ-023 SHALL register sa_advance=0 and sa_inputs=0 in any cycle without a pop or flush advance: sa_hold=1, FIFO empty in STREAM, or IDLE.
REQ-024 SHALL keep accepting vectors during FLUSH; pops resume only after returning to IDLE.
REQ-025 SHALL, on a simultaneous push and pop, leave fifo_count unchanged, including when fifo_count equals FIFO_DEPTH-1 or 1.
REQ-026 SHALL, when STREAM finds the FIFO empty, remain in STREAM, advance nothing, and wait for the last-flagged vector.
REQ-027 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-028 SHALL drive busy = (state != IDLE).

Reset
REQ-029 SHALL, while resetn=0 at an edge, set state=IDLE, FIFO empty, pointers=0, drain counter=0, sa_advance=0, sa_inputs=0, flush_done=0, and in_ready=1 after that edge.
REQ-030 SHALL, on reset mid-STREAM or mid-FLUSH, discard all buffered vectors and abandon the drain, with no flush_done pulse.

Structure
REQ-031 SHALL define feeder_state_t (IDLE/STREAM/FLUSH) in GEMM_pkg.
REQ-032 SHALL instantiate one sub-module, gemm_act_fifo: synchronous FIFO, parameterised width and depth, exposing count, full and empty.

Verification
REQ-033 SHALL cover: SA_SIZE=2, push {2,5} with last=1 into an empty feeder -> sa_advance=1 with sa_inputs={2,5} two edges after acceptance, then exactly 4 zero-input advances, flush_done one cycle later, busy low.
REQ-034 SHALL cover: push 5 vectors with sa_hold=1 and FIFO_DEPTH=4 -> in_ready=0 after 4 accepts, fifo_count=4; the 5th is accepted only after sa_hold drops and a pop occurs.
REQ-035 SHALL cover: toggle sa_hold every cycle during FLUSH -> 4 advances total; flush_done delayed accordingly, never early.
REQ-036 SHALL cover: vectors {1,1},{2,2}(last) then {3,3} pushed during FLUSH -> {3,3} is not emitted until the cycle after flush_done.
REQ-037 SHALL cover: assert resetn=0 after 2 of 4 flush advances -> sa_advance=0, fifo_count=0, no flush_done.
REQ-038 SHALL cover: continuous push and pop at steady state with fifo_count=2 -> fifo_count stays 2 and output order matches input order across pointer wrap.
